// File: rtl/csmulti_accumulator.sv
// csmulti_accumulator: back half of a MAC unit. Registers the product of the
// upstream carry-save array multiplier through a valid/ready handshake, sums a
// programmed number of products into a wide wrapping accumulator, and presents
// the result behind a held valid/ready output handshake.
module csmulti_accumulator #(
    parameter int BITSIZE = 8,
    parameter int ACC_W   = 24,
    parameter int LEN_W   = 8
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start,
    input  logic [LEN_W-1:0]       len,
    output logic                   busy,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2*BITSIZE-1:0]   product,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ACC_W-1:0]       acc_out,
    output logic                   overflow
);

    localparam int PROD_W = 2 * BITSIZE;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    state_t              r_state;
    state_t              w_state_nxt;
    logic [LEN_W-1:0]    r_remaining;
    logic [PROD_W-1:0]   r_p_reg;
    logic                r_p_vld;
    logic [ACC_W-1:0]    r_acc;
    logic                r_overflow;

    logic                w_in_ready;
    logic                w_hs;
    logic                w_start_job;
    logic                w_last_hs;
    logic [ACC_W:0]      w_sum;

    // Input side control, decoded from registered state only
    always_comb begin
        w_in_ready  = (r_state == S_ACCUM) && (r_remaining != {LEN_W{1'b0}});
        w_hs        = in_valid & w_in_ready;
        w_start_job = (r_state == S_IDLE) & start;
        w_last_hs   = w_hs && (r_remaining == LEN_W'(1));
    end

    // Add stage: unsigned sum with one extra bit to capture the wrap carry
    always_comb begin
        w_sum = {1'b0, r_acc} + {{(ACC_W + 1 - PROD_W){1'b0}}, r_p_reg};
    end

    // Next-state logic for the job sequencer
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (len != {LEN_W{1'b0}}) begin
                        w_state_nxt = S_ACCUM;
                    end else begin
                        w_state_nxt = S_DONE;
                    end
                end else begin
                    w_state_nxt = S_IDLE;
                end
            end
            S_ACCUM: begin
                if (w_last_hs) begin
                    w_state_nxt = S_DRAIN;
                end else begin
                    w_state_nxt = S_ACCUM;
                end
            end
            S_DRAIN: begin
                w_state_nxt = S_DONE;
            end
            S_DONE: begin
                if (out_ready) begin
                    w_state_nxt = S_IDLE;
                end else begin
                    w_state_nxt = S_DONE;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Term counter: loaded at start, decremented on every accepted product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_remaining <= {LEN_W{1'b0}};
        end else if (w_start_job) begin
            r_remaining <= len;
        end else if (w_hs) begin
            r_remaining <= r_remaining - LEN_W'(1);
        end else begin
            r_remaining <= r_remaining;
        end
    end

    // Product capture register: breaks the multiplier's long array path
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_reg <= {PROD_W{1'b0}};
            r_p_vld <= 1'b0;
        end else if (w_hs) begin
            r_p_reg <= product;
            r_p_vld <= 1'b1;
        end else begin
            r_p_reg <= r_p_reg;
            r_p_vld <= 1'b0;
        end
    end

    // Accumulator and sticky overflow: cleared at start, updated when a product is pending
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_acc      <= {ACC_W{1'b0}};
            r_overflow <= 1'b0;
        end else if (w_start_job) begin
            r_acc      <= {ACC_W{1'b0}};
            r_overflow <= 1'b0;
        end else if (r_p_vld) begin
            r_acc      <= w_sum[ACC_W-1:0];
            r_overflow <= r_overflow | w_sum[ACC_W];
        end else begin
            r_acc      <= r_acc;
            r_overflow <= r_overflow;
        end
    end

    // Output decode from registers
    always_comb begin
        busy      = (r_state != S_IDLE);
        out_valid = (r_state == S_DONE);
        in_ready  = w_in_ready;
        acc_out   = r_acc;
        overflow  = r_overflow;
    end

endmodule
